pipeline_hazard_controller: RTL

- Central hazard and sequencing controller for the 5-stage RISC-V pipeline; replaces the constant PCWrite/IF_ID_Write/PCSrc/flush ties.
- Detects load-use hazards, branch/jump redirects and data-memory wait states; drives the stage write-enables, flushes and EX forwarding selects.
- Holds a freeze/timeout FSM so a slow data memory stalls the whole pipe safely.

---
 rtl/pipeline_hazard_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Drives stage enables, flushes, PC select and EX forwarding; freezes on slow memory.
//
// Ports:
//   clk, reset (sync, active-low)
//   ID:  rs1_id, rs2_id, use_rs1_id, use_rs2_id
//   EX:  rs1_ex, rs2_ex, rd_ex, MemRead_ex, branch_taken_ex
//   MEM: rd_mem, RegWrite_mem, MemAccess_mem, mem_ready
//   WB:  rd_wb, RegWrite_wb
//   out: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
//        PCSrc, IF_ID_Flush, ID_EX_Flush, ForwardA, ForwardB, halted
//   HAZARD_PERF_EN adds stall_cycles, flush_events, freeze_cycles.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [REG_W-1:0] rs1_ex,
    input  logic [REG_W-1:0] rs2_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             MemRead_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic             RegWrite_mem,
    input  logic             MemAccess_mem,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             RegWrite_wb,
    input  logic             branch_taken_ex,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             PCSrc,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
    output logic [31:0]      freeze_cycles
`endif
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;

    logic mem_busy;
    logic halt_st;
    logic live;
    logic load_use;
    logic do_halt;
    logic do_freeze;
    logic do_redirect;
    logic do_stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign mem_busy = MemAccess_mem & ~mem_ready;
    assign halt_st  = (state == HALT);
    assign live     = reset & ~halt_st;

    assign load_use = MemRead_ex & (rd_ex != '0) &
                      ((use_rs1_id & (rs1_id == rd_ex)) |
                       (use_rs2_id & (rs2_id == rd_ex)));

    // Mutually exclusive actions, in priority order.
    assign do_halt     = reset & halt_st;
    assign do_freeze   = live & mem_busy;
    assign do_redirect = live & ~mem_busy & branch_taken_ex;
    assign do_stall    = live & ~mem_busy & ~branch_taken_ex & load_use;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                wait_cnt_nxt = '0;
                if (mem_busy) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        PCSrc        = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        halted       = 1'b0;
        unique case (1'b1)
            do_halt: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
                MEM_WB_Write = 1'b0;
                halted       = 1'b1;
            end
            do_freeze: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
                MEM_WB_Write = 1'b0;
            end
            do_redirect: begin
                PCSrc       = 1'b1;
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            do_stall: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // MEM/EX result beats the older WB result; x0 is never forwarded.
    assign fwd_a = (RegWrite_mem && rd_mem != '0 && rd_mem == rs1_ex) ? 2'b10 :
                   (RegWrite_wb && rd_wb != '0 && rd_wb == rs1_ex)    ? 2'b01 :
                                                                        2'b00;
    assign fwd_b = (RegWrite_mem && rd_mem != '0 && rd_mem == rs2_ex) ? 2'b10 :
                   (RegWrite_wb && rd_wb != '0 && rd_wb == rs2_ex)    ? 2'b01 :
                                                                        2'b00;

    assign ForwardA = live ? fwd_a : 2'b00;
    assign ForwardB = live ? fwd_b : 2'b00;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles  <= '0;
            flush_events  <= '0;
            freeze_cycles <= '0;
        end else begin
            if (do_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (do_redirect && flush_events != '1)
                flush_events <= flush_events + 32'd1;
            if (do_freeze && freeze_cycles != '1)
                freeze_cycles <= freeze_cycles + 32'd1;
        end
    end
`endif

endmodule
